// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: FSM states, funct3 op codes and
// result error codes.
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_D  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;
    localparam logic [2:0] OP_WU = 3'b110;
    localparam logic [2:0] OP_XX = 3'b111;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_BUS      = 2'b11;

    // Illegal wins over misaligned: an illegal op has no meaningful size.
    function automatic logic [1:0] precheck_err(input logic illegal, input logic misaligned);
        if (illegal)
            return ERR_ILLEGAL;
        else if (misaligned)
            return ERR_MISALIGN;
        else
            return ERR_OK;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: byte mask, store data placement, load
// extraction with sign/zero extension, and op legality/alignment checks.
module lsu_lane
    import lsu_ctrl_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [2:0]        op,
    input  logic              wen,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [NB-1:0]     wmask,
    output logic [DATA_W-1:0] wdata_sh,
    output logic [DATA_W-1:0] rdata_ext,
    output logic              misaligned,
    output logic              illegal
);

    logic [NB-1:0]            size_mask;
    logic [OFF_W-1:0]         align_mask;
    logic [6:0]               ext_sh;
    logic [DATA_W-1:0]        rd_sh;
    logic [DATA_W-1:0]        rd_top;
    logic signed [DATA_W-1:0] rd_sext;

    always_comb begin
        size_mask  = NB'(8'h01);
        align_mask = '0;
        ext_sh     = 7'(DATA_W - 8);
        case (op[1:0])
            2'b00: begin
                size_mask  = NB'(8'h01);
                align_mask = '0;
                ext_sh     = 7'(DATA_W - 8);
            end
            2'b01: begin
                size_mask  = NB'(8'h03);
                align_mask = OFF_W'(1);
                ext_sh     = 7'(DATA_W - 16);
            end
            2'b10: begin
                size_mask  = NB'(8'h0F);
                align_mask = OFF_W'(3);
                ext_sh     = 7'(DATA_W - 32);
            end
            default: begin
                size_mask  = NB'(8'hFF);
                align_mask = OFF_W'(7);
                ext_sh     = 7'd0;
            end
        endcase
    end

    assign illegal    = (op == OP_XX) || (op[2] && wen) ||
                        ((DATA_W == 32) && ((op == OP_D) || (op == OP_WU)));
    assign misaligned = |(offset & align_mask);

    assign wmask    = size_mask << offset;
    assign wdata_sh = wdata << {offset, 3'b000};

    // Push the field to the top, then shift back down to extend it.
    assign rd_sh     = rdata >> {offset, 3'b000};
    assign rd_top    = rd_sh << ext_sh;
    assign rd_sext   = $signed(rd_top) >>> ext_sh;
    assign rdata_ext = op[2] ? (rd_top >> ext_sh) : rd_sext;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: accepts one op from the EXU, prechecks it, issues a single
// lane-aligned bus request, waits with a timeout and returns the result.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wen,
    input  logic [2:0]          in_op,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic [1:0]          out_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_wen,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    input  logic                mem_rsp_err,
    output logic [1:0]          dbg_state
);

    localparam int         NB       = DATA_W / 8;
    localparam int         OFF_W    = $clog2(NB);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t              state, state_nx;
    logic                r_wen;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          err_q;
    logic [15:0]         cnt;
    logic                timeout_hit;

    logic [2:0]          ln_op;
    logic                ln_wen;
    logic [OFF_W-1:0]    ln_off;
    logic [NB-1:0]       ln_wmask;
    logic [DATA_W-1:0]   ln_wdata;
    logic [DATA_W-1:0]   ln_rdata;
    logic                ln_misaligned;
    logic                ln_illegal;

    // The lane checks the incoming op while idle and the captured op afterwards.
    assign ln_op  = (state == ST_IDLE) ? in_op  : r_op;
    assign ln_wen = (state == ST_IDLE) ? in_wen : r_wen;
    assign ln_off = (state == ST_IDLE) ? in_addr[OFF_W-1:0] : r_addr[OFF_W-1:0];

    lsu_lane #(.DATA_W(DATA_W)) u_lane (
        .op         (ln_op),
        .wen        (ln_wen),
        .offset     (ln_off),
        .wdata      (r_wdata),
        .rdata      (mem_rsp_rdata),
        .wmask      (ln_wmask),
        .wdata_sh   (ln_wdata),
        .rdata_ext  (ln_rdata),
        .misaligned (ln_misaligned),
        .illegal    (ln_illegal)
    );

    assign timeout_hit = (cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Handshakes: a transfer happens on a cycle where valid && ready are both
    // high; a valid side keeps its payload stable until that cycle.
    always_comb begin
        state_nx      = state;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_wen   = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = (ln_illegal || ln_misaligned) ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_wen   = r_wen;
                mem_req_addr  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                mem_req_wdata = ln_wdata;
                mem_req_wmask = ln_wmask;
                if (mem_req_ready)
                    state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid || timeout_hit)
                    state_nx = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_wen   <= in_wen;
                        r_op    <= in_op;
                        r_addr  <= in_addr;
                        r_wdata <= in_wdata;
                        rdata_q <= '0;
                        err_q   <= precheck_err(ln_illegal, ln_misaligned);
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready)
                        cnt <= '0;
                end
                ST_WAIT: begin
                    cnt <= cnt + 16'd1;
                    // A response in the timeout cycle still wins.
                    if (mem_rsp_valid) begin
                        if (mem_rsp_err)
                            err_q <= ERR_BUS;
                        else if (!r_wen)
                            rdata_q <= ln_rdata;
                    end else if (timeout_hit) begin
                        err_q <= ERR_BUS;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_rdata = rdata_q;
    assign out_err   = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a 32-bit unit (TIMEOUT=4) and a 64-bit unit
// share stimulus; only the selected one is ever given in_valid.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid32, in_valid64;
    logic        in_wen;
    logic [2:0]  in_op;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic        out_ready;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        mem_rsp_err;

    logic        in_ready32, out_valid32, mreq_valid32, mreq_wen32;
    logic [31:0] out_rdata32, mreq_addr32, mreq_wdata32;
    logic [1:0]  out_err32, dbg32;
    logic [3:0]  mreq_wmask32;

    logic        in_ready64, out_valid64, mreq_valid64, mreq_wen64;
    logic [63:0] out_rdata64, mreq_wdata64;
    logic [31:0] mreq_addr64;
    logic [1:0]  out_err64, dbg64;
    logic [7:0]  mreq_wmask64;

    logic        sel64;
    logic        obs_in_ready, obs_out_valid, obs_req_valid, obs_req_wen;
    logic [63:0] obs_rdata, obs_req_wdata;
    logic [31:0] obs_req_addr;
    logic [7:0]  obs_req_wmask;
    logic [1:0]  obs_err, obs_state;

    logic [63:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid32), .in_ready(in_ready32), .in_wen(in_wen), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready), .out_rdata(out_rdata32), .out_err(out_err32),
        .mem_req_valid(mreq_valid32), .mem_req_ready(mem_req_ready), .mem_req_wen(mreq_wen32),
        .mem_req_addr(mreq_addr32), .mem_req_wdata(mreq_wdata32), .mem_req_wmask(mreq_wmask32),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata[31:0]), .mem_rsp_err(mem_rsp_err),
        .dbg_state(dbg32)
    );

    lsu_ctrl #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(16)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_wen(in_wen), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid64), .out_ready(out_ready), .out_rdata(out_rdata64), .out_err(out_err64),
        .mem_req_valid(mreq_valid64), .mem_req_ready(mem_req_ready), .mem_req_wen(mreq_wen64),
        .mem_req_addr(mreq_addr64), .mem_req_wdata(mreq_wdata64), .mem_req_wmask(mreq_wmask64),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .dbg_state(dbg64)
    );

    always_comb begin
        if (sel64) begin
            obs_in_ready  = in_ready64;
            obs_out_valid = out_valid64;
            obs_req_valid = mreq_valid64;
            obs_req_wen   = mreq_wen64;
            obs_rdata     = out_rdata64;
            obs_req_wdata = mreq_wdata64;
            obs_req_addr  = mreq_addr64;
            obs_req_wmask = mreq_wmask64;
            obs_err       = out_err64;
            obs_state     = dbg64;
        end else begin
            obs_in_ready  = in_ready32;
            obs_out_valid = out_valid32;
            obs_req_valid = mreq_valid32;
            obs_req_wen   = mreq_wen32;
            obs_rdata     = {32'h0, out_rdata32};
            obs_req_wdata = {32'h0, mreq_wdata32};
            obs_req_addr  = mreq_addr32;
            obs_req_wmask = {4'h0, mreq_wmask32};
            obs_err       = out_err32;
            obs_state     = dbg32;
        end
    end

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic issue(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                         input logic [63:0] wdata);
        in_wen   = wen;
        in_op    = op;
        in_addr  = addr;
        in_wdata = wdata;
        if (sel64) in_valid64 = 1'b1;
        else       in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        in_valid64 = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [1:0] exp_err);
        logic [63:0] exp_rd;
        check_eq({tag, ".out_valid"}, obs_out_valid, 1);
        check_eq({tag, ".err"}, obs_err, exp_err);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.queue: got empty queue expected an entry", tag);
        end else begin
            exp_rd = exp_q.pop_front();
            check_eq({tag, ".rdata"}, obs_rdata, exp_rd);
        end
    endtask

    task automatic finish_resp(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, ".idle_state"}, obs_state, 0);
        check_eq({tag, ".idle_in_ready"}, obs_in_ready, 1);
        check_eq({tag, ".idle_out_valid"}, obs_out_valid, 0);
    endtask

    // Zero-wait bus, response in the first WAIT cycle: out_valid at cycle 3.
    task automatic txn(input string tag, input logic wen, input logic [2:0] op,
                       input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rsp,
                       input logic [63:0] exp_rdata, input logic [31:0] exp_addr,
                       input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
        exp_q.push_back(exp_rdata);
        mem_req_ready = 1'b1;
        issue(wen, op, addr, wdata);
        check_eq({tag, ".req_valid"}, obs_req_valid, 1);
        check_eq({tag, ".in_ready"}, obs_in_ready, 0);
        check_eq({tag, ".req_wen"}, obs_req_wen, wen);
        check_eq({tag, ".req_addr"}, obs_req_addr, exp_addr);
        check_eq({tag, ".req_mask"}, obs_req_wmask, exp_mask);
        check_eq({tag, ".req_wdata"}, obs_req_wdata, exp_wdata);
        tick();
        check_eq({tag, ".wait_state"}, obs_state, 2);
        check_eq({tag, ".single_req"}, obs_req_valid, 0);
        check_eq({tag, ".early_valid"}, obs_out_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rsp;
        tick();
        mem_rsp_valid = 1'b0;
        check_result(tag, 2'b00);
        finish_resp(tag);
    endtask

    // Rejected op: result at cycle 1, no bus request.
    task automatic precheck(input string tag, input logic wen, input logic [2:0] op,
                            input logic [31:0] addr, input logic [1:0] exp_err);
        exp_q.push_back(64'h0);
        issue(wen, op, addr, 64'h5555_5555_5555_5555);
        check_eq({tag, ".no_req"}, obs_req_valid, 0);
        check_eq({tag, ".state"}, obs_state, 3);
        check_result(tag, exp_err);
        finish_resp(tag);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        sel64         = 1'b0;
        rst           = 1'b1;
        in_valid32    = 1'b0;
        in_valid64    = 1'b0;
        in_wen        = 1'b0;
        in_op         = 3'b000;
        in_addr       = 32'h0;
        in_wdata      = 64'h0;
        out_ready     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 64'h0;
        mem_rsp_err   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state of both units
        for (int s = 0; s < 2; s++) begin
            sel64 = (s == 1);
            check_eq("rst.state", obs_state, 0);
            check_eq("rst.in_ready", obs_in_ready, 1);
            check_eq("rst.out_valid", obs_out_valid, 0);
            check_eq("rst.rdata", obs_rdata, 0);
            check_eq("rst.err", obs_err, 0);
            check_eq("rst.req_valid", obs_req_valid, 0);
            check_eq("rst.req_addr", obs_req_addr, 0);
            check_eq("rst.req_wdata", obs_req_wdata, 0);
            check_eq("rst.req_mask", obs_req_wmask, 0);
        end

        // 32-bit datapath
        sel64 = 1'b0;
        txn("lb32", 1'b0, 3'b000, 32'h8000_0003, 64'h0, 64'h80FF_1234,
            64'hFFFF_FF80, 32'h8000_0000, 8'h08, 64'h0);
        txn("sh32", 1'b1, 3'b001, 32'h8000_0002, 64'hABCD, 64'hDEAD_BEEF,
            64'h0, 32'h8000_0000, 8'h0C, 64'hABCD_0000);
        txn("lbu32", 1'b0, 3'b100, 32'h8000_0001, 64'h0, 64'h0000_A500,
            64'h0000_00A5, 32'h8000_0000, 8'h02, 64'h0);
        txn("lh32", 1'b0, 3'b001, 32'h8000_0002, 64'h0, 64'h8001_0000,
            64'hFFFF_8001, 32'h8000_0000, 8'h0C, 64'h0);

        precheck("lw_mis", 1'b0, 3'b010, 32'h8000_0001, 2'b01);
        precheck("lh_mis", 1'b0, 3'b001, 32'h8000_0003, 2'b01);
        precheck("ld_on32", 1'b0, 3'b011, 32'h8000_0000, 2'b10);
        precheck("lwu_on32", 1'b0, 3'b110, 32'h8000_0000, 2'b10);
        precheck("op111", 1'b0, 3'b111, 32'h8000_0000, 2'b10);
        precheck("sbu", 1'b1, 3'b100, 32'h8000_0000, 2'b10);

        // Timeout: 4 WAIT cycles with no response
        exp_q.push_back(64'h0);
        mem_req_ready = 1'b1;
        issue(1'b0, 3'b010, 32'h8000_0000, 64'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("tmo.wait", obs_state, 2);
            check_eq("tmo.no_valid", obs_out_valid, 0);
            tick();
        end
        check_result("tmo", 2'b11);
        finish_resp("tmo");

        // Response in the timeout cycle wins
        exp_q.push_back(64'h1234_5678);
        issue(1'b0, 3'b010, 32'h8000_0004, 64'h0);
        tick();
        for (int i = 0; i < 3; i++) tick();
        check_eq("tmo_race.wait", obs_state, 2);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        check_result("tmo_race", 2'b00);
        finish_resp("tmo_race");

        // Bus error response
        exp_q.push_back(64'h0);
        issue(1'b0, 3'b010, 32'h8000_0008, 64'h0);
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = 1'b1;
        mem_rsp_rdata = 64'h7777_7777;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        check_result("buserr", 2'b11);
        finish_resp("buserr");

        // Backpressure on request and result
        mem_req_ready = 1'b0;
        issue(1'b0, 3'b101, 32'h8000_0002, 64'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready = 1'b1;
            check_eq("bp.req_valid", obs_req_valid, 1);
            check_eq("bp.req_addr", obs_req_addr, 32'h8000_0000);
            check_eq("bp.req_mask", obs_req_wmask, 8'h0C);
            check_eq("bp.req_wen", obs_req_wen, 0);
            tick();
        end
        check_eq("bp.wait", obs_state, 2);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hBEEF_0000;
        tick();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(64'h0000_BEEF);
            check_result("bp.hold", 2'b00);
            if (i < 2) tick();
        end
        finish_resp("bp");

        // Reset while waiting; the late response must be ignored
        issue(1'b0, 3'b010, 32'h8000_0008, 64'h0);
        tick();
        check_eq("rstwait.wait", obs_state, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstwait.state", obs_state, 0);
        check_eq("rstwait.in_ready", obs_in_ready, 1);
        check_eq("rstwait.req_valid", obs_req_valid, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hCAFE_F00D;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("late_rsp.state", obs_state, 0);
            check_eq("late_rsp.out_valid", obs_out_valid, 0);
        end
        mem_rsp_valid = 1'b0;

        // 64-bit datapath
        sel64 = 1'b1;
        txn("lwu64", 1'b0, 3'b110, 32'h0000_0008, 64'h0, 64'h0000_0000_F000_0000,
            64'h0000_0000_F000_0000, 32'h0000_0008, 8'h0F, 64'h0);
        txn("lw64_hi", 1'b0, 3'b010, 32'h0000_000C, 64'h0, 64'hF000_0000_0000_0000,
            64'hFFFF_FFFF_F000_0000, 32'h0000_0008, 8'hF0, 64'h0);
        txn("ld64", 1'b0, 3'b011, 32'h0000_0010, 64'h0, 64'h0123_4567_89AB_CDEF,
            64'h0123_4567_89AB_CDEF, 32'h0000_0010, 8'hFF, 64'h0);
        txn("sb64", 1'b1, 3'b000, 32'h0000_001D, 64'h5A, 64'h0,
            64'h0, 32'h0000_0018, 8'h20, 64'h0000_5A00_0000_0000);
        precheck("ld64_mis", 1'b0, 3'b011, 32'h0000_0014, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
